// File: rtl/uart_mmio_pkg.sv
// Shared types and register-map constants for the UART TX MMIO FIFO responder.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    TXF_IDLE      = 2'd0,
    TXF_SEND      = 2'd1,
    TXF_WAIT_DONE = 2'd2
  } txf_state_t;

  // Register select is A[2]
  localparam logic OFF_TXDATA = 1'b0;
  localparam logic OFF_STATUS = 1'b1;

  localparam int unsigned ST_FULL_BIT  = 0;
  localparam int unsigned ST_EMPTY_BIT = 1;
  localparam int unsigned ST_BUSY_BIT  = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo_byte.sv
// Byte-wide synchronous FIFO with power-of-two depth and wrapping pointers.
module sync_fifo_byte #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [7:0]       mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is still legal when the head leaves on the same edge
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio_fifo.sv
// MMIO responder: core stores fill a byte FIFO that a drain FSM feeds to the UART TX.
module uart_tx_mmio_fifo
  import uart_mmio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1001_0040,
  parameter int unsigned           DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] WD,
  output logic [DATA_WIDTH-1:0] RD,
  output logic                  sel,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic                  tx_done,
  output logic                  irq_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  txf_state_t       state_q, state_d;
  logic             ovf_q, ovf_d;
  logic             wr_txdata, wr_status;
  logic             pop, push_ok, ovf_set, ovf_clr;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0] status;
  logic             unused_bits;

  assign unused_bits = ^{WD[DATA_WIDTH-1:8], A[1:0]};

  assign sel       = (A[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
  assign wr_txdata = we && sel && (A[2] == OFF_TXDATA);
  assign wr_status = we && sel && (A[2] == OFF_STATUS);

  assign pop     = (state_q == TXF_SEND) && tx_ready;
  assign push_ok = wr_txdata && (!fifo_full || pop);
  assign ovf_set = wr_txdata && fifo_full && !pop;
  assign ovf_clr = wr_status && WD[ST_OVF_BIT];

  sync_fifo_byte #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .din   (WD[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      TXF_IDLE: begin
        if (fifo_count != '0) state_d = TXF_SEND;
      end
      TXF_SEND: begin
        tx_valid = 1'b1;
        tx_data  = fifo_dout;
        if (tx_ready) state_d = TXF_WAIT_DONE;
      end
      TXF_WAIT_DONE: begin
        // No pop here, so the post-edge count is the current count plus any push
        if (tx_done) state_d = ((fifo_count != '0) || push_ok) ? TXF_SEND : TXF_IDLE;
      end
      default: state_d = TXF_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TXF_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    status                            = '0;
    status[ST_FULL_BIT]               = fifo_full;
    status[ST_EMPTY_BIT]              = fifo_empty;
    status[ST_BUSY_BIT]               = (state_q != TXF_IDLE);
    status[ST_OVF_BIT]                = ovf_q;
    status[ST_COUNT_LSB +: CNT_W]     = fifo_count;
    RD = '0;
    if (re && sel && (A[2] == OFF_STATUS)) RD = status;
  end

  assign irq_empty = fifo_empty && (state_q == TXF_IDLE);

endmodule

// File: tb/tb_uart_tx_mmio_fifo.sv
// Directed bench: vector table for single-byte flow and decode, hand sequences for FIFO corners.
module tb_uart_tx_mmio_fifo;

  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [31:0] A, WD;
  logic [31:0] RD;
  logic        sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready, tx_done;
  logic        irq_empty;

  int unsigned total  = 0;
  int unsigned passed = 0;
  logic [7:0]  exp_bytes [16];

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        tr;
    logic        tdone;
    logic [31:0] rd;
    logic        tv;
    logic [7:0]  tdat;
    logic        irq;
    logic        sel;
  } vec_t;

  vec_t vecs [17];

  always #5 clk = ~clk;

  uart_tx_mmio_fifo #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .BASE_ADDR (32'h1001_0040),
    .DEPTH     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .re        (re),
    .we        (we),
    .A         (A),
    .WD        (WD),
    .RD        (RD),
    .sel       (sel),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .irq_empty (irq_empty)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else passed++;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; A = addr; WD = data;
    @(negedge clk);
    we = 1'b0; WD = '0;
  endtask

  task automatic expect_status(input string name, input logic [31:0] exp);
    re = 1'b1; A = BASE + 32'd4;
    #1;
    check(name, RD, exp);
  endtask

  // Starts at a negedge with the FSM in SEND or about to be; ends at a negedge
  task automatic drain(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned waited;
      waited = 0;
      tx_ready = 1'b1;
      #1;
      while (!tx_valid && waited < 50) begin
        @(negedge clk); #1; waited++;
      end
      check($sformatf("%s_valid%0d", tag, i), {31'd0, tx_valid}, 32'd1);
      if (!tx_valid) begin
        tx_ready = 1'b0;
        return;
      end
      check($sformatf("%s_byte%0d", tag, i), {24'd0, tx_data}, {24'd0, exp_bytes[i]});
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            re  we  addr          wd            tr  tdn rd            tv  tdat   irq sel
    vecs[0]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, BASE,       32'h41,       1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0100, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b1, 1'b0, 32'h0000_0104, 1'b1, 8'h41, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b1, 1'b0, 32'h0000_0006, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b1, 32'h0000_0006, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b1, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, BASE+32'd8, 32'h55,       1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, BASE,       32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, BASE+32'd8, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, BASE+32'd5, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 1'b1, BASE+32'd4, 32'hFFFF_FFF7, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, BASE+32'd4, 32'h0,        1'b0, 1'b0, 32'h0000_0002, 1'b0, 8'h00, 1'b1, 1'b1};

    rst = 1'b0; re = 1'b1; we = 1'b0; A = BASE + 32'd4; WD = '0;
    tx_ready = 1'b0; tx_done = 1'b0;
    #1;
    check("reset_status", RD, 32'h0000_0002);
    check("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("reset_irq", {31'd0, irq_empty}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int unsigned i = 0; i < 17; i++) begin
      re = vecs[i].re; we = vecs[i].we; A = vecs[i].a; WD = vecs[i].wd;
      tx_ready = vecs[i].tr; tx_done = vecs[i].tdone;
      #1;
      check($sformatf("v%0d_rd", i),   RD,                        vecs[i].rd);
      check($sformatf("v%0d_tv", i),   {31'd0, tx_valid},         {31'd0, vecs[i].tv});
      check($sformatf("v%0d_tdat", i), {24'd0, tx_data},          {24'd0, vecs[i].tdat});
      check($sformatf("v%0d_irq", i),  {31'd0, irq_empty},        {31'd0, vecs[i].irq});
      check($sformatf("v%0d_sel", i),  {31'd0, sel},              {31'd0, vecs[i].sel});
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0; WD = '0; tx_ready = 1'b0; tx_done = 1'b0;

    // Overflow: nine pushes into eight slots while the UART is stalled
    for (int unsigned i = 0; i < 9; i++) bus_write(BASE, 32'(i + 1));
    expect_status("ovf_status", 32'h0000_080D);
    check("ovf_head", {24'd0, tx_data}, 32'h01);
    @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) exp_bytes[i] = 8'(i + 1);
    drain(8, "ovf_drain");
    expect_status("ovf_after_drain", 32'h0000_000A);
    check("ovf_no_ninth", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    bus_write(BASE + 32'd4, 32'h8);
    expect_status("ovf_cleared", 32'h0000_0002);
    @(negedge clk);

    // Push into a full FIFO on the same edge the head is popped
    for (int unsigned i = 0; i < 8; i++) bus_write(BASE, 32'h0000_00B0 + 32'(i));
    expect_status("full_send_status", 32'h0000_0805);
    @(negedge clk);
    we = 1'b1; A = BASE; WD = 32'hAA; tx_ready = 1'b1;
    #1;
    check("full_push_pop_tv", {31'd0, tx_valid}, 32'd1);
    check("full_push_pop_head", {24'd0, tx_data}, 32'hB0);
    @(negedge clk);
    we = 1'b0; WD = '0; tx_ready = 1'b0;
    expect_status("full_push_pop_status", 32'h0000_0805);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    for (int unsigned i = 0; i < 7; i++) exp_bytes[i] = 8'hB1 + 8'(i);
    exp_bytes[7] = 8'hAA;
    drain(8, "full_drain");
    expect_status("full_drain_status", 32'h0000_0002);
    @(negedge clk);

    // Asynchronous reset while waiting for a frame, then a stray tx_done
    for (int unsigned i = 0; i < 4; i++) bus_write(BASE, 32'h0000_00C0 + 32'(i));
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    expect_status("pre_reset_status", 32'h0000_0304);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_status", RD, 32'h0000_0002);
    check("async_reset_tv", {31'd0, tx_valid}, 32'd0);
    check("async_reset_irq", {31'd0, irq_empty}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    expect_status("stray_done_status", 32'h0000_0002);
    check("stray_done_tv", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    expect_status("stray_done_status2", 32'h0000_0002);
    check("stray_done_irq", {31'd0, irq_empty}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
